wb_commit_stage: RTL and testbench

- Parametrised N-lane writeback/commit pipeline stage between MEM and ctrl/regfile.
- Replaces the fixed dual-lane register, which zeroes its contents on a pause. This block adds:
  - a valid/ready handshake with a 2-entry skid buffer, so a stall holds data instead of dropping it;
  - a separate flush;
  - in-order exception truncation;
  - same-destination write resolution;
  - a retired-instruction counter.

---
 rtl/wb_commit_stage.sv | 200 ++++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// wb_commit_stage
//   N-lane writeback/commit stage between MEM and ctrl/regfile.
//   The input side uses a valid/ready handshake backed by a main entry (M),
//   which drives out_*, and a skid entry (S). A stall holds both entries
//   bit-for-bit. flush empties both entries. A bundle is cleaned up as it is
//   captured: lanes after the oldest exception are dropped, the excepting
//   lane loses its side effects, and GPR/CSR writes to the same destination
//   are resolved so the younger lane wins.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous flush (drops M, S and any offered bundle)
//   in_valid/in_ready   input handshake (in_ready = !S.valid, registered)
//   in_*                per-lane bundle fields from MEM (lane i at [W*i +: W])
//   out_valid/out_ready output handshake towards ctrl
//   out_*               committed bundle fields, registered from M
//   out_exc_*           exception summary of the committed bundle
//   retire_cnt          retired instruction count (wraps)
module wb_commit_stage #(
  parameter  int LANES  = 2,
  parameter  int XLEN   = 32,
  parameter  int CSR_AW = 14,
  parameter  int EXC_W  = 6,
  parameter  int CNT_W  = 32,
  localparam int EW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_valid,
  input  logic [LANES-1:0]         in_rf_we,
  input  logic [LANES*5-1:0]       in_rf_waddr,
  input  logic [LANES*XLEN-1:0]    in_rf_wdata,
  input  logic [LANES-1:0]         in_csr_we,
  input  logic [LANES*CSR_AW-1:0]  in_csr_addr,
  input  logic [LANES*XLEN-1:0]    in_csr_wdata,
  input  logic [LANES*EXC_W-1:0]   in_exc,
  input  logic [LANES*XLEN-1:0]    in_pc,
  input  logic [LANES-1:0]         in_ertn,
  input  logic [LANES-1:0]         in_idle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_valid,
  output logic [LANES-1:0]         out_rf_we,
  output logic [LANES*5-1:0]       out_rf_waddr,
  output logic [LANES*XLEN-1:0]    out_rf_wdata,
  output logic [LANES-1:0]         out_csr_we,
  output logic [LANES*CSR_AW-1:0]  out_csr_addr,
  output logic [LANES*XLEN-1:0]    out_csr_wdata,
  output logic [LANES*XLEN-1:0]    out_pc,
  output logic [LANES-1:0]         out_ertn,
  output logic [LANES-1:0]         out_idle,
  output logic                     out_exc_valid,
  output logic [EW-1:0]            out_exc_lane,
  output logic [EXC_W-1:0]         out_exc_code,
  output logic [CNT_W-1:0]         retire_cnt
);

  typedef struct packed {
    logic [LANES-1:0]        lane_valid;
    logic [LANES-1:0]        rf_we;
    logic [LANES*5-1:0]      rf_waddr;
    logic [LANES*XLEN-1:0]   rf_wdata;
    logic [LANES-1:0]        csr_we;
    logic [LANES*CSR_AW-1:0] csr_addr;
    logic [LANES*XLEN-1:0]   csr_wdata;
    logic [LANES*XLEN-1:0]   pc;
    logic [LANES-1:0]        ertn;
    logic [LANES-1:0]        idle;
    logic                    exc_valid;
    logic [EW-1:0]           exc_lane;
    logic [EXC_W-1:0]        exc_code;
  } entry_t;

  entry_t m_q, s_q, cap;
  logic   m_valid, s_valid;
  logic   accept, drain;

  // Capture-time processing scratch
  logic             found;
  int unsigned      k;
  logic [EXC_W-1:0] k_code;
  logic [LANES-1:0] lv, rf_raw, csr_raw;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid && out_ready;

  function automatic logic [CNT_W-1:0] popcnt(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    cap     = '0;
    found   = 1'b0;
    k       = 0;
    k_code  = '0;
    lv      = '0;
    rf_raw  = '0;
    csr_raw = '0;

    // Oldest excepting lane
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!found && in_lane_valid[i] && (in_exc[i*EXC_W +: EXC_W] != '0)) begin
        found  = 1'b1;
        k      = i;
        k_code = in_exc[i*EXC_W +: EXC_W];
      end
    end

    cap.rf_waddr  = in_rf_waddr;
    cap.rf_wdata  = in_rf_wdata;
    cap.csr_addr  = in_csr_addr;
    cap.csr_wdata = in_csr_wdata;
    cap.pc        = in_pc;
    cap.exc_valid = found;
    cap.exc_lane  = found ? EW'(k) : '0;
    cap.exc_code  = k_code;

    for (int unsigned i = 0; i < LANES; i++) begin
      lv[i]         = in_lane_valid[i] && !(found && (i > k));
      rf_raw[i]     = in_rf_we[i] && lv[i] && (in_rf_waddr[i*5 +: 5] != 5'd0)
                      && !(found && (i == k));
      csr_raw[i]    = in_csr_we[i] && lv[i] && !(found && (i == k));
      cap.ertn[i]   = in_ertn[i] && !(found && (i == k));
      cap.idle[i]   = in_idle[i] && !(found && (i == k));
    end
    cap.lane_valid = lv;

    // Younger lane wins on a shared destination
    cap.rf_we  = rf_raw;
    cap.csr_we = csr_raw;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (rf_raw[i] && rf_raw[j] && (in_rf_waddr[i*5 +: 5] == in_rf_waddr[j*5 +: 5]))
          cap.rf_we[i] = 1'b0;
        if (csr_raw[i] && csr_raw[j] &&
            (in_csr_addr[i*CSR_AW +: CSR_AW] == in_csr_addr[j*CSR_AW +: CSR_AW]))
          cap.csr_we[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (drain) retire_cnt <= retire_cnt + popcnt(m_q.lane_valid);
      if (flush) begin
        m_q     <= '0;
        s_q     <= '0;
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (m_valid && !drain) begin
        // M stalled: only the skid entry can take a new bundle
        if (accept) begin
          s_q     <= cap;
          s_valid <= 1'b1;
        end
      end else if (s_valid) begin
        // M is draining with S occupied (in_ready is low, so no accept here)
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_q     <= '0;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q     <= cap;
        m_valid <= 1'b1;
      end else begin
        m_q     <= '0;
        m_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = m_valid;
  assign out_lane_valid = m_q.lane_valid;
  assign out_rf_we      = m_q.rf_we;
  assign out_rf_waddr   = m_q.rf_waddr;
  assign out_rf_wdata   = m_q.rf_wdata;
  assign out_csr_we     = m_q.csr_we;
  assign out_csr_addr   = m_q.csr_addr;
  assign out_csr_wdata  = m_q.csr_wdata;
  assign out_pc         = m_q.pc;
  assign out_ertn       = m_q.ertn;
  assign out_idle       = m_q.idle;
  assign out_exc_valid  = m_q.exc_valid;
  assign out_exc_lane   = m_q.exc_lane;
  assign out_exc_code   = m_q.exc_code;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage (LANES=2, CNT_W=4 so counter wrap is
// reachable). Inputs change #1 after the rising edge; outputs are checked
// at that same point, i.e. they reflect the edge just taken.
module tb_wb_commit_stage;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int CAW   = 14;
  localparam int EXC_W = 6;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0]       in_lane_valid, in_rf_we, in_csr_we, in_ertn, in_idle;
  logic [LANES*5-1:0]     in_rf_waddr;
  logic [LANES*XLEN-1:0]  in_rf_wdata, in_csr_wdata, in_pc;
  logic [LANES*CAW-1:0]   in_csr_addr;
  logic [LANES*EXC_W-1:0] in_exc;
  logic [LANES-1:0]       out_lane_valid, out_rf_we, out_csr_we, out_ertn, out_idle;
  logic [LANES*5-1:0]     out_rf_waddr;
  logic [LANES*XLEN-1:0]  out_rf_wdata, out_csr_wdata, out_pc;
  logic [LANES*CAW-1:0]   out_csr_addr;
  logic                   out_exc_valid;
  logic [0:0]             out_exc_lane;
  logic [EXC_W-1:0]       out_exc_code;
  logic [CNT_W-1:0]       retire_cnt;

  int nvec = 0;
  int nerr = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [LANES*XLEN-1:0] held_data;

  always #5 clk = ~clk;

  wb_commit_stage #(.LANES(LANES), .XLEN(XLEN), .CSR_AW(CAW), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr),
    .in_csr_wdata(in_csr_wdata), .in_exc(in_exc), .in_pc(in_pc), .in_ertn(in_ertn),
    .in_idle(in_idle), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
    .out_rf_wdata(out_rf_wdata), .out_csr_we(out_csr_we), .out_csr_addr(out_csr_addr),
    .out_csr_wdata(out_csr_wdata), .out_pc(out_pc), .out_ertn(out_ertn), .out_idle(out_idle),
    .out_exc_valid(out_exc_valid), .out_exc_lane(out_exc_lane), .out_exc_code(out_exc_code),
    .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_lane_valid = '0; in_rf_we = '0; in_rf_waddr = '0; in_rf_wdata = '0;
    in_csr_we = '0; in_csr_addr = '0; in_csr_wdata = '0; in_exc = '0; in_pc = '0;
    in_ertn = '0; in_idle = '0;
  endtask

  // Offer a bundle: fields packed {lane1, lane0}
  task automatic offer(input logic [1:0] lv, input logic [1:0] we,
                       input logic [4:0] a1, input logic [4:0] a0,
                       input logic [31:0] d1, input logic [31:0] d0,
                       input logic [5:0] e1, input logic [5:0] e0);
    idle_inputs();
    in_valid = 1; in_lane_valid = lv; in_rf_we = we; in_rf_waddr = {a1, a0};
    in_rf_wdata = {d1, d0}; in_exc = {e1, e0}; in_pc = {32'h1c000004, 32'h1c000000};
  endtask

  initial begin
    idle_inputs();
    flush = 0; out_ready = 1; rst = 1;
    step(); step();
    rst = 0;
    exp_cnt = '0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_rf_we", out_rf_we, 0);

    // Streaming
    offer(2'b11, 2'b11, 5'd4, 5'd3, 32'hAAAA0004, 32'hAAAA0003, 0, 0);
    step();
    check("str_valid", out_valid, 1);
    check("str_pc", out_pc, {32'h1c000004, 32'h1c000000});
    check("str_rf_we", out_rf_we, 2'b11);
    check("str_waddr", out_rf_waddr, {5'd4, 5'd3});
    offer(2'b11, 2'b11, 5'd4, 5'd3, 32'hBBBB0004, 32'hBBBB0003, 0, 0);
    step(); exp_cnt += 2;
    check("str_data_b", out_rf_wdata, {32'hBBBB0004, 32'hBBBB0003});
    check("str_cnt1", retire_cnt, exp_cnt);
    idle_inputs();
    step(); exp_cnt += 2;
    check("str_empty", out_valid, 0);
    check("str_cnt2", retire_cnt, exp_cnt);

    // Stall: M holds C, S takes D
    out_ready = 0;
    offer(2'b11, 2'b11, 5'd6, 5'd7, 32'hCCCC0001, 32'hCCCC0000, 0, 0);
    step();
    check("stl_in_ready0", in_ready, 1);
    held_data = out_rf_wdata;
    offer(2'b11, 2'b11, 5'd8, 5'd9, 32'hDDDD0001, 32'hDDDD0000, 0, 0);
    step();
    check("stl_in_ready1", in_ready, 0);
    check("stl_hold1", out_rf_wdata, held_data);
    offer(2'b11, 2'b11, 5'd10, 5'd11, 32'hEEEE0001, 32'hEEEE0000, 0, 0);
    step();
    check("stl_hold2", out_rf_wdata, {32'hCCCC0001, 32'hCCCC0000});
    check("stl_hold_addr", out_rf_waddr, {5'd6, 5'd7});
    check("stl_cnt", retire_cnt, exp_cnt);
    idle_inputs(); out_ready = 1;
    step(); exp_cnt += 2;
    check("stl_rel_d", out_rf_wdata, {32'hDDDD0001, 32'hDDDD0000});
    check("stl_rel_ready", in_ready, 1);
    check("stl_rel_cnt", retire_cnt, exp_cnt);
    step(); exp_cnt += 2;
    check("stl_rel_empty", out_valid, 0);

    // Exception on lane 0
    offer(2'b11, 2'b11, 5'd4, 5'd3, 32'h1, 32'h2, 6'h00, 6'h0B);
    in_ertn = 2'b01;
    step();
    check("exc0_valid", out_exc_valid, 1);
    check("exc0_lane", out_exc_lane, 0);
    check("exc0_code", out_exc_code, 6'h0B);
    check("exc0_lv", out_lane_valid, 2'b01);
    check("exc0_rf_we", out_rf_we, 2'b00);
    check("exc0_ertn", out_ertn, 2'b00);
    // Exception on lane 1
    offer(2'b11, 2'b11, 5'd4, 5'd7, 32'h1, 32'h2, 6'h05, 6'h00);
    step(); exp_cnt += 1;
    check("exc1_lane", out_exc_lane, 1);
    check("exc1_code", out_exc_code, 6'h05);
    check("exc1_lv", out_lane_valid, 2'b11);
    check("exc1_rf_we", out_rf_we, 2'b01);

    // Same destination, GPR and CSR
    offer(2'b11, 2'b11, 5'd5, 5'd5, 32'h22, 32'h11, 0, 0);
    in_csr_we = 2'b11; in_csr_addr = {14'h100, 14'h100};
    step(); exp_cnt += 2;
    check("sd_rf_we", out_rf_we, 2'b10);
    check("sd_csr_we", out_csr_we, 2'b10);
    check("sd_exc_valid", out_exc_valid, 0);
    offer(2'b10, 2'b10, 5'd0, 5'd0, 32'h33, 32'h0, 0, 0);
    step(); exp_cnt += 2;
    check("z0_rf_we", out_rf_we, 2'b00);
    check("z0_lv", out_lane_valid, 2'b10);
    offer(2'b01, 2'b11, 5'd9, 5'd8, 32'h44, 32'h55, 0, 0);
    step(); exp_cnt += 1;
    check("inv_rf_we", out_rf_we, 2'b01);
    idle_inputs();
    step(); exp_cnt += 1;
    check("pre_flush_cnt", retire_cnt, exp_cnt);

    // Flush with M and S full and a bundle offered
    out_ready = 0;
    offer(2'b11, 2'b11, 5'd1, 5'd2, 32'hF1, 32'hF0, 0, 0);
    step();
    offer(2'b11, 2'b11, 5'd1, 5'd2, 32'hF3, 32'hF2, 0, 0);
    step();
    check("fl_sfull", in_ready, 0);
    flush = 1;
    step();
    flush = 0; idle_inputs();
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_data", out_rf_wdata, 0);
    check("fl_cnt", retire_cnt, exp_cnt);
    step();
    check("fl_stays_empty", out_valid, 0);
    // Flush while M drains: the drained bundle still counts
    out_ready = 1;
    offer(2'b11, 2'b11, 5'd1, 5'd2, 32'hF5, 32'hF4, 0, 0);
    step();
    flush = 1; idle_inputs();
    step(); exp_cnt += 2;
    flush = 0;
    check("fl_drain_cnt", retire_cnt, exp_cnt);
    check("fl_drain_valid", out_valid, 0);

    // Reset mid-stall discards both entries
    out_ready = 0;
    offer(2'b01, 2'b01, 5'd0, 5'd3, 0, 32'h7, 0, 0);
    step(); step();
    rst = 1; idle_inputs();
    step();
    rst = 0;
    check("rs_valid", out_valid, 0);
    check("rs_ready", in_ready, 1);
    check("rs_cnt", retire_cnt, 0);

    // Counter wrap: 15 single-lane drains then one 2-lane drain
    out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      offer(2'b01, 2'b01, 5'd0, 5'd3, 0, i, 0, 0);
      step();
    end
    offer(2'b11, 2'b11, 5'd4, 5'd3, 0, 0, 0, 0);
    step();
    check("wr_cnt15", retire_cnt, 15);
    idle_inputs();
    step();
    check("wr_cnt1", retire_cnt, 1);
    check("wr_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
